// File: rtl/video_dma_pkg.sv
// Shared types and constants for the video DMA fetch block.
package video_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    BURST = 2'd2
  } dma_state_e;

  localparam int BURST_WORDS = 4;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/dma_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// Head data reads as zero while empty so the output is clean out of reset.
module dma_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [31:0]   pop_data,
  output logic [AW:0]   level,
  output logic          empty
);

  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (level == '0);
  assign do_push  = push && (level != FULL_LVL);
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; flush overrides any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/video_dma_fetch.sv
// Wishbone 4-beat incrementing-burst fetcher feeding a FWFT FIFO.
// Optional feature: define VIDEO_DMA_FETCH_UNDERRUN_EN to add the
// saturating underrun_cnt output.
module video_dma_fetch
  import video_dma_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          enable,
  input  logic          restart,
  input  logic [23:0]   start_addr,
  input  logic [23:0]   end_addr,
  output logic [23:0]   wb_adr,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [3:0]    wb_sel,
  output logic [31:0]   wb_dat_o,
  output logic [2:0]    wb_cti,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic          empty,
  output logic [LW-1:0] level
`ifdef VIDEO_DMA_FETCH_UNDERRUN_EN
  ,
  output logic [15:0]   underrun_cnt
`endif
);

  // A burst may only start when at least BURST_WORDS slots are free.
  localparam logic [LW-1:0] START_LIMIT = LW'(FIFO_DEPTH - BURST_WORDS);
  localparam logic [1:0]    LAST_BEAT   = 2'(BURST_WORDS - 1);

  dma_state_e  state;
  dma_state_e  state_nxt;
  logic [23:0] fetch_addr;
  logic [23:0] next_addr;
  logic [23:0] start_aligned;
  logic        restart_pend;
  logic [1:0]  beat_cnt;
  logic        ack_take;
  logic        last_ack;
  logic        start_burst;
  logic        flush;
  logic        push;
  logic        unused_bits;

  assign start_aligned = {start_addr[23:4], 4'h0};
  assign next_addr     = (fetch_addr[23:4] == end_addr[23:4]) ? start_aligned
                                                              : fetch_addr + 24'h10;
  assign ack_take      = wb_cyc && wb_ack;
  assign last_ack      = ack_take && (beat_cnt == LAST_BEAT);
  assign start_burst   = (state == IDLE) && enable && !restart && !restart_pend
                         && (level <= START_LIMIT);
  assign flush         = ((state == IDLE) && restart)
                         || (last_ack && (restart || restart_pend));
  // Words of a burst hit by a restart are dropped; the flush at burst end clears the rest.
  assign push          = ack_take && !restart && !restart_pend;

  assign wb_stb   = wb_cyc;
  assign wb_we    = 1'b0;
  assign wb_sel   = 4'hF;
  assign wb_dat_o = '0;

  assign unused_bits = ^{start_addr[3:0], end_addr[3:0], CTI_END};

  // State register.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_burst) state_nxt = REQ;
      REQ:     if (ack_take)    state_nxt = BURST;
      BURST:   if (last_ack)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Bus request, beat counting, fetch address and restart bookkeeping.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wb_cyc       <= 1'b0;
      wb_adr       <= '0;
      wb_cti       <= CTI_CLASSIC;
      beat_cnt     <= '0;
      fetch_addr   <= '0;
      restart_pend <= 1'b0;
    end else begin
      if (start_burst) begin
        wb_cyc   <= 1'b1;
        wb_adr   <= fetch_addr;
        wb_cti   <= CTI_INCR;
        beat_cnt <= '0;
      end
      if (ack_take) beat_cnt <= beat_cnt + 2'd1;
      if (last_ack) begin
        wb_cyc       <= 1'b0;
        wb_cti       <= CTI_CLASSIC;
        restart_pend <= 1'b0;
        fetch_addr   <= (restart || restart_pend) ? start_aligned : next_addr;
      end else if ((state != IDLE) && restart) begin
        restart_pend <= 1'b1;
      end
      if ((state == IDLE) && restart) fetch_addr <= start_aligned;
    end
  end

  dma_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk),
    .rst_n     (wb_rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (wb_dat_i),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .level     (level),
    .empty     (empty)
  );

`ifdef VIDEO_DMA_FETCH_UNDERRUN_EN
  // Count consumer reads attempted against an empty FIFO, saturating.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n)                                 underrun_cnt <= '0;
    else if (restart)                              underrun_cnt <= '0;
    else if (rd_en && empty && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_video_dma_fetch.sv
// Randomized bench for video_dma_fetch against a queue-based reference model.
module tb_video_dma_fetch;

  localparam int DEPTH = 16;

  logic        wb_clk   = 1'b0;
  logic        wb_rst_n = 1'b1;
  logic        enable   = 1'b0;
  logic        restart  = 1'b0;
  logic [23:0] start_addr = '0;
  logic [23:0] end_addr   = '0;
  logic [23:0] wb_adr;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_o;
  logic [2:0]  wb_cti;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack   = 1'b0;
  logic        rd_en    = 1'b0;
  logic [31:0] rd_data;
  logic        empty;
  logic [4:0]  level;
`ifdef VIDEO_DMA_FETCH_UNDERRUN_EN
  logic [15:0] underrun_cnt;
`endif

  always #5 wb_clk = ~wb_clk;

  video_dma_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .enable     (enable),
    .restart    (restart),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .wb_adr     (wb_adr),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_dat_o   (wb_dat_o),
    .wb_cti     (wb_cti),
    .wb_dat_i   (wb_dat_i),
    .wb_ack     (wb_ack),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .level      (level)
`ifdef VIDEO_DMA_FETCH_UNDERRUN_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: FIFO contents, bus activity and address sequence.
  bit [31:0] q[$];
  bit        m_cyc;
  int        m_acks;
  bit        m_pend;
  bit [23:0] m_addr;
  int        m_unr;

  task automatic model_reset();
    q.delete();
    m_cyc  = 1'b0;
    m_acks = 0;
    m_pend = 1'b0;
    m_addr = '0;
    m_unr  = 0;
  endtask

  typedef struct packed {
    logic [23:0] s;
    logic [23:0] e;
    int          en_pct;
    int          rd_pct;
    int          ack_pct;
    int          rst_pm;
    int          cycles;
  } phase_t;

  phase_t ph [5];

  task automatic check_outputs();
    check_val("cyc", wb_cyc, m_cyc);
    check_val("stb", wb_stb, m_cyc);
    if (m_cyc) begin
      check_val("adr", wb_adr, m_addr);
      check_val("cti", wb_cti, 32'h2);
    end
    check_val("level", level, q.size());
    check_val("empty", empty, q.size() == 0);
    if (q.size() > 0) check_val("rd_data", rd_data, q[0]);
    check_val("const", {wb_we, wb_sel, wb_dat_o[26:0]}, {1'b0, 4'hF, 27'h0});
`ifdef VIDEO_DMA_FETCH_UNDERRUN_EN
    check_val("underrun", underrun_cnt, m_unr);
`endif
  endtask

  // One cycle: check state, drive new inputs, advance the model to the next edge.
  task automatic step(input phase_t p, input bit force_rst);
    int lvl;
    bit [23:0] start_al;
    @(negedge wb_clk);
    check_outputs();
    start_addr = p.s;
    end_addr   = p.e;
    enable     = ($urandom_range(99) < p.en_pct);
    rd_en      = ($urandom_range(99) < p.rd_pct);
    restart    = force_rst || ($urandom_range(999) < p.rst_pm);
    wb_ack     = m_cyc && ($urandom_range(99) < p.ack_pct);
    wb_dat_i   = $urandom;
    start_al   = {start_addr[23:4], 4'h0};

    lvl = q.size();
    if (restart) m_unr = 0;
    else if (rd_en && lvl == 0 && m_unr < 65535) m_unr++;
    if (rd_en && lvl > 0) void'(q.pop_front());
    if (m_cyc) begin
      if (wb_ack) begin
        if (!restart && !m_pend) q.push_back(wb_dat_i);
        m_acks++;
      end
      if (restart) m_pend = 1'b1;
      if (m_acks == 4) begin
        m_cyc  = 1'b0;
        m_acks = 0;
        if (m_pend) begin
          q.delete();
          m_addr = start_al;
          m_pend = 1'b0;
        end else if (m_addr[23:4] == end_addr[23:4]) begin
          m_addr = start_al;
        end else begin
          m_addr = m_addr + 24'h10;
        end
      end
    end else if (restart) begin
      q.delete();
      m_addr = start_al;
    end else if (enable && (DEPTH - lvl) >= 4) begin
      m_cyc = 1'b1;
    end
  endtask

  initial begin
    ph[0] = '{24'h000100, 24'h000120, 100,   0, 100,  0,  60};
    ph[1] = '{24'h000100, 24'h000120, 100,  30,  60,  0, 300};
    ph[2] = '{24'h000100, 24'h000120,  80,  50,  50, 50, 400};
    ph[3] = '{24'hFFFFE7, 24'h00001C, 100,  60,  70, 10, 300};
    ph[4] = '{24'h000200, 24'h000230,  30, 100, 100, 30, 200};

    model_reset();
    #1 wb_rst_n = 1'b0;
    #3;
    check_outputs();
    check_val("rst_adr", wb_adr, 0);
    check_val("rst_cti", wb_cti, 0);
    check_val("rst_rd_data", rd_data, 0);
    @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;

    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < ph[p].cycles; c++) step(ph[p], c == 0 && p != 0);
    end

    // Reset asserted while a burst is on the bus.
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
        step(ph[1], 1'b0);
        if (wb_cyc && m_cyc) seen = 1'b1;
      end
      check_val("burst_seen", seen, 1);
    end
    #2 wb_rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_val("rst_adr", wb_adr, 0);
    check_val("rst_cti", wb_cti, 0);
    check_val("rst_rd_data", rd_data, 0);
    enable = 1'b0;
    wb_ack = 1'b1;
    @(posedge wb_clk);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge wb_clk);
      check_val("post_rst_level", level, 0);
      check_val("post_rst_cyc", wb_cyc, 0);
    end
    wb_ack = 1'b0;
    for (int c = 0; c < 150; c++) step(ph[2], c == 0);
    @(negedge wb_clk);
    check_outputs();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
